// File: rtl/mipi_tx_payload_sched_if.sv
// Requester handshakes and pixel-generator output bus of the MIPI TX payload
// scheduler. The master side is the requesters plus the pixel data generator;
// the slave side is the scheduler itself.
interface mipi_tx_payload_sched_if #(
  parameter int DLEN = 64
);
  logic                req0_valid;
  logic [DLEN*8-1:0]   req0_data;
  logic                req0_ready;
  logic                req1_valid;
  logic [DLEN*8-1:0]   req1_data;
  logic                req1_ready;
  logic [DLEN*8-1:0]   pix_gen_data;
  logic                data_available;
  logic                grant_id;
  logic [15:0]         frames_sent;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  pix_gen_data, data_available, grant_id, frames_sent
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output pix_gen_data, data_available, grant_id, frames_sent
  );
endinterface

// File: rtl/mipi_tx_payload_sched.sv
// MIPI TX payload scheduler: accepts one payload from two round-robin
// requesters, waits for a frame vsync edge, then presents the payload to the
// pixel data generator for REPEAT frames before returning to idle.
//
// Handshake: reqN_ready is a single-cycle accept strobe decoded from the
// current state. It is high only in IDLE, out of reset, without flush, and
// only for the requester that wins arbitration; the payload is taken on the
// rising edge where reqN_valid && reqN_ready. At most one ready is high.
module mipi_tx_payload_sched #(
  parameter int DLEN   = 64,
  parameter int REPEAT = 2
) (
  input  logic                         tx_pixel_clk,
  input  logic                         rst_n,
  input  logic                         frame_vsync,
  input  logic                         flush,
  mipi_tx_payload_sched_if.slave       bus,
  output logic [1:0]                   state_dbg
);

  localparam int         W          = DLEN * 8;
  localparam logic [3:0] REPEAT_CNT = 4'(REPEAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t         state;
  logic           vsync_prev;
  logic           last_grant;
  logic [3:0]     frame_cnt;
  logic [W-1:0]   payload_q;
  logic           data_avail_q;
  logic           grant_q;
  logic [15:0]    frames_sent_q;

  logic           vsync_rise;
  logic           win_id;
  logic           accept;
  logic [3:0]     cnt_next;

  // Edge detect, round-robin winner and accept decode for the current cycle.
  always_comb begin
    vsync_rise = frame_vsync & ~vsync_prev;
    cnt_next   = frame_cnt + 4'd1;
    win_id     = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      // Both asking: the one not granted last time wins.
      win_id = ~last_grant;
    end else if (bus.req1_valid) begin
      win_id = 1'b1;
    end
    accept = rst_n && (state == IDLE) && !flush &&
             (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready     = accept & ~win_id;
  assign bus.req1_ready     = accept &  win_id;
  assign bus.pix_gen_data   = payload_q;
  assign bus.data_available = data_avail_q;
  assign bus.grant_id       = grant_q;
  assign bus.frames_sent    = frames_sent_q;
  assign state_dbg          = state;

  // Scheduler FSM with its registered outputs and the vsync history bit.
  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vsync_prev    <= 1'b1;  // a vsync already high at release is not an edge
      last_grant    <= 1'b1;  // requester 0 wins the first contested arbitration
      frame_cnt     <= 4'd0;
      payload_q     <= '0;
      data_avail_q  <= 1'b0;
      grant_q       <= 1'b0;
      frames_sent_q <= 16'd0;
    end else begin
      vsync_prev <= frame_vsync;
      case (state)
        IDLE: begin
          if (accept) begin
            payload_q  <= win_id ? bus.req1_data : bus.req0_data;
            grant_q    <= win_id;
            last_grant <= win_id;
            state      <= ARM;
          end
        end
        ARM: begin
          if (flush) begin
            state <= IDLE;
          end else if (vsync_rise) begin
            state        <= SEND;
            data_avail_q <= 1'b1;
            frame_cnt    <= 4'd0;
          end
        end
        SEND: begin
          if (flush) begin
            // Abort wins over a coincident vsync edge: nothing is counted.
            state        <= IDLE;
            data_avail_q <= 1'b0;
          end else if (vsync_rise) begin
            frame_cnt     <= cnt_next;
            frames_sent_q <= frames_sent_q + 16'd1;
            if (cnt_next == REPEAT_CNT) begin
              state        <= IDLE;
              data_avail_q <= 1'b0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          data_avail_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_tx_payload_sched.sv
// Bench for mipi_tx_payload_sched: a table of arbitration vectors plus
// hand-written sequences for vsync-at-reset, flush, reset mid-send and
// frames_sent wrap. Accepted payloads go into an expected queue and are
// compared when data_available rises.
module tb_mipi_tx_payload_sched;

  localparam int DLEN   = 4;
  localparam int W      = DLEN * 8;
  localparam int REPEAT = 2;
  localparam int GAP    = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic vsync;
  logic flush;
  logic [1:0] state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mipi_tx_payload_sched_if #(.DLEN(DLEN)) bus ();

  mipi_tx_payload_sched #(
    .DLEN   (DLEN),
    .REPEAT (REPEAT)
  ) dut (
    .tx_pixel_clk (clk),
    .rst_n        (rst_n),
    .frame_vsync  (vsync),
    .flush        (flush),
    .bus          (bus),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int              n_vec = 0;
  int              n_err = 0;
  logic [W:0]      exp_q[$];
  logic [15:0]     exp_frames;
  logic            da_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: strobe exclusivity and payload scoreboard on data_available rise.
  always @(negedge clk) begin
    logic [W:0] e;
    if (bus.req0_ready && bus.req1_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_overlap: got both ready strobes high, expected at most one");
    end
    if (bus.data_available && !da_prev) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_empty: data_available rose, expected no payload pending");
      end else begin
        e = exp_q.pop_front();
        check("sb_payload", {31'd0, bus.grant_id, bus.pix_gen_data}, {31'd0, e});
      end
    end
    da_prev = bus.data_available;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Called #1 after an edge with vsync low; returns #1 after the edge that saw it high.
  task automatic vsync_pulse();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
  endtask

  task automatic wait_accept(input logic exp_id, input logic [W-1:0] exp_data, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no ready in 20 cycles, expected grant to %0d", name, exp_id);
    end else begin
      check({name, "_strobe"}, {62'd0, bus.req1_ready, bus.req0_ready},
            exp_id ? 64'd2 : 64'd1);
      exp_q.push_back({exp_id, exp_data});
    end
    cyc();
    check({name, "_grant_id"}, {63'd0, bus.grant_id}, {63'd0, exp_id});
    check({name, "_latched"}, {32'd0, bus.pix_gen_data}, {32'd0, exp_data});
    check({name, "_armed_da"}, {63'd0, bus.data_available}, 64'd0);
  endtask

  // Arm edge, then REPEAT counted frames with gap cycles between pulses.
  task automatic run_frames(input int gap, input logic [W-1:0] exp_data, input string name);
    cyc();
    vsync_pulse();
    check({name, "_first_da"}, {63'd0, bus.data_available}, 64'd1);
    for (int f = 1; f <= REPEAT; f++) begin
      cyc_n(gap);
      vsync_pulse();
      exp_frames = exp_frames + 16'd1;
      check({name, "_frames"}, {48'd0, bus.frames_sent}, {48'd0, exp_frames});
      check({name, "_da"}, {63'd0, bus.data_available}, (f < REPEAT) ? 64'd1 : 64'd0);
    end
    check({name, "_hold"}, {32'd0, bus.pix_gen_data}, {32'd0, exp_data});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         v0;
    logic         v1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         exp_id;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected winners assume requester 0 won the last arbitration before the table.
    tbl[0] = '{1'b1, 1'b1, 32'h1000_0000, 32'h2000_0000, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 32'h1000_0001, 32'h2000_0001, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h1000_0002, 32'h2000_0002, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 32'h1000_0003, 32'h2000_0003, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 32'h1000_0004, 32'h2000_0004, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h1000_0005, 32'h2000_0005, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 32'h1000_0006, 32'h2000_0006, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'h1000_0007, 32'h2000_0007, 1'b1};

    // Reset with vsync high and requester 0 already asking.
    rst_n          = 1'b0;
    vsync          = 1'b1;
    flush          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hA5A5_A5A5;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    exp_frames     = 16'd0;
    cyc_n(3);
    check("rst_da",     {63'd0, bus.data_available}, 64'd0);
    check("rst_grant",  {63'd0, bus.grant_id}, 64'd0);
    check("rst_frames", {48'd0, bus.frames_sent}, 64'd0);
    check("rst_pix",    {32'd0, bus.pix_gen_data}, 64'd0);
    check("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    check("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    check("rst_state",  {62'd0, state_dbg}, 64'd0);
    rst_n = 1'b1;

    // Vsync held high through release: no send until a genuine 0->1 edge.
    wait_accept(1'b0, 32'hA5A5_A5A5, "a");
    bus.req0_valid = 1'b0;
    cyc_n(3);
    check("a_vsync_high_no_send", {63'd0, bus.data_available}, 64'd0);
    vsync = 1'b0;
    cyc_n(2);
    check("a_vsync_low_no_send", {63'd0, bus.data_available}, 64'd0);
    run_frames(100, 32'hA5A5_A5A5, "a");

    // Arbitration table.
    for (int i = 0; i < 8; i++) begin
      bus.req0_valid = tbl[i].v0;
      bus.req0_data  = tbl[i].d0;
      bus.req1_valid = tbl[i].v1;
      bus.req1_data  = tbl[i].d1;
      wait_accept(tbl[i].exp_id, tbl[i].exp_id ? tbl[i].d1 : tbl[i].d0, "tbl");
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      run_frames(GAP, tbl[i].exp_id ? tbl[i].d1 : tbl[i].d0, "tbl");
    end

    // Flush during SEND after one frame, coincident with a vsync edge.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hB0B0_B0B0;
    wait_accept(1'b0, 32'hB0B0_B0B0, "b");
    bus.req0_valid = 1'b0;
    cyc();
    vsync_pulse();
    check("b_send_da", {63'd0, bus.data_available}, 64'd1);
    cyc_n(GAP);
    vsync_pulse();
    exp_frames = exp_frames + 16'd1;
    check("b_frame1", {48'd0, bus.frames_sent}, {48'd0, exp_frames});
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'hB1B1_B1B1;
    cyc_n(2);
    #4;
    check("b_no_ready_in_send", {63'd0, bus.req1_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    check("b_flush_da",     {63'd0, bus.data_available}, 64'd0);
    check("b_flush_frames", {48'd0, bus.frames_sent}, {48'd0, exp_frames});
    #4;
    check("b_flush_blocks_idle", {63'd0, bus.req1_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_accept(1'b1, 32'hB1B1_B1B1, "b_pending");
    bus.req1_valid = 1'b0;

    // Reset asserted mid-SEND, requester 1 alone waiting at release.
    cyc();
    vsync_pulse();
    check("c_send_da", {63'd0, bus.data_available}, 64'd1);
    cyc_n(2);
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'hC1C1_C1C1;
    rst_n = 1'b0;
    #2;
    check("c_rst_da",     {63'd0, bus.data_available}, 64'd0);
    check("c_rst_frames", {48'd0, bus.frames_sent}, 64'd0);
    check("c_rst_pix",    {32'd0, bus.pix_gen_data}, 64'd0);
    check("c_rst_grant",  {63'd0, bus.grant_id}, 64'd0);
    check("c_rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    cyc();
    rst_n      = 1'b1;
    exp_frames = 16'd0;
    wait_accept(1'b1, 32'hC1C1_C1C1, "c");
    bus.req1_valid = 1'b0;
    run_frames(GAP, 32'hC1C1_C1C1, "c");

    // frames_sent wrap from 0xFFFF.
    force dut.frames_sent_q = 16'hFFFF;
    #1;
    release dut.frames_sent_q;
    cyc();
    exp_frames = 16'hFFFF;
    check("d_preload", {48'd0, bus.frames_sent}, {48'd0, exp_frames});
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hD0D0_D0D0;
    wait_accept(1'b0, 32'hD0D0_D0D0, "d");
    bus.req0_valid = 1'b0;
    run_frames(GAP, 32'hD0D0_D0D0, "d");

    cyc_n(2);
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mipi_tx_payload_sched.md
MIPI_TX_PAYLOAD_SCHED -- requirements
Module: mipi_tx_payload_sched

Interface
REQ-001 The module SHALL have parameter DLEN, default 64, giving the payload length in bytes (bus width DLEN*8).
REQ-002 The module SHALL have parameter REPEAT, default 2, giving the number of frames each payload is transmitted (legal range 1..15).
REQ-003 tx_pixel_clk  in  1  The single clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  Asynchronous, active-low reset.
REQ-005 req0_valid  in  1  Requester 0 has a payload.
REQ-006 req0_data  in  DLEN*8  Requester 0 payload.
REQ-007 req0_ready  out  1  Single-cycle accept strobe to requester 0.
REQ-008 req1_valid, req1_data, req1_ready SHALL be identical to REQ-005..007 for requester 1.
REQ-009 frame_vsync  in  1  Frame sync from the video generator; active high.
REQ-010 flush  in  1  Synchronous abort of the current payload.
REQ-011 pix_gen_data  out  DLEN*8  Payload presented to the pixel data generator.
REQ-012 data_available  out  1  pix_gen_data is valid for transmission.
REQ-013 grant_id  out  1  Requester whose payload is currently held.
REQ-014 frames_sent  out  16  Count of completed payload frames; wraps at 0xFFFF -> 0.

Function
REQ-015 States SHALL be IDLE, ARM, SEND.
REQ-016 IDLE: if any reqN_valid, the module SHALL accept exactly one request, pulse that reqN_ready for one cycle, latch reqN_data into the payload buffer, set grant_id=N, and go to ARM next cycle.
REQ-017 Arbitration: one valid request SHALL be granted directly; for simultaneous valid requests, the requester not granted last SHALL win (round-robin), and requester 0 SHALL win the first arbitration after reset.
REQ-018 reqN_ready SHALL never be asserted outside IDLE; at most one ready SHALL be high per cycle.
REQ-019 A vsync rising edge SHALL be detected as frame_vsync=1 with the registered previous value=0; the registered value SHALL reset to 1, so a vsync already high at reset release produces no edge.
REQ-020 ARM: on a vsync rising edge, the module SHALL go to SEND, assert data_available and clear the frame counter, with all changes in the same registered update; a rising edge in the acceptance cycle SHALL NOT be counted.
REQ-021 SEND: data_available SHALL stay high and pix_gen_data SHALL stay stable.
REQ-022 SEND: each vsync rising edge SHALL increment the frame counter and frames_sent.
REQ-023 SEND: when the frame counter reaches REPEAT, the module SHALL deassert data_available and enter IDLE in the same update.
REQ-024 Latency from reqN_ready to the first data_available SHALL be one cycle after the next vsync rising edge.
REQ-025 pix_gen_data SHALL hold the last payload after SEND until the next acceptance.
REQ-026 flush=1 in ARM or SEND SHALL return the module to IDLE on the next edge and deassert data_available, with no frames_sent increment.
REQ-027 flush in IDLE SHALL block acceptance that cycle.
REQ-028 flush SHALL take priority over a coincident vsync edge.

Reset
REQ-029 While rst_n=0, the module SHALL be in IDLE, with pix_gen_data=0, data_available=0, grant_id=0, frames_sent=0, req0_ready=0, req1_ready=0, internal frame counter=0 and round-robin pointer set so requester 0 wins next.
REQ-030 Reset asserted mid-SEND SHALL drop data_available asynchronously; requests pending at reset release SHALL be arbitrated from IDLE.

Verification
REQ-031 REPEAT=2, req0_valid with data 0xA5.., vsync pulses every 100 cycles -> req0_ready pulses one cycle; data_available rises one cycle after the next vsync edge and falls after the 2nd subsequent edge; frames_sent=2.
REQ-032 req0 and req1 both valid from reset -> grant order 0,1,0,1 across four payloads; ready strobes never overlap; grant_id tracks each payload.
REQ-033 vsync held high through reset release, then toggled -> no SEND before the first genuine 0->1 edge.
REQ-034 flush during SEND after 1 frame -> data_available=0 next cycle, frames_sent unchanged by the aborted frame, and the next pending request is accepted from IDLE.
REQ-035 rst_n low mid-SEND -> all outputs 0 immediately; after release, req1 alone valid -> accepted, grant_id=1.
REQ-036 Preload frames_sent=0xFFFF by forcing -> the next completed frame gives 0x0000.
